// File: rtl/perceptron_pkg.sv
// Shared definitions for the time-multiplexed perceptron.
// Default geometry, FSM state encoding, the fixed-point 1.0 constant and
// a WIDTH-bit signed saturating adder used by the weight-update pass.
package perceptron_pkg;

  localparam int unsigned N_INPUTS_D = 4;
  localparam int unsigned WIDTH_D    = 6;
  localparam int unsigned FRAC_D     = 3;
  localparam int unsigned ACC_W_D    = 12;

  typedef enum logic [2:0] {IDLE, MAC, DECIDE, UPDATE, DONE} state_e;

  localparam logic signed [WIDTH_D-1:0] ONE  = WIDTH_D'(1 << FRAC_D);
  localparam logic signed [WIDTH_D-1:0] SMAX = {1'b0, {(WIDTH_D-1){1'b1}}};
  localparam logic signed [WIDTH_D-1:0] SMIN = {1'b1, {(WIDTH_D-1){1'b0}}};

  // One guard bit catches overflow: if the two top bits of the sum differ,
  // the true result is out of range and the guard bit gives its sign.
  function automatic logic signed [WIDTH_D-1:0] sat_add(
    input logic signed [WIDTH_D-1:0] a,
    input logic signed [WIDTH_D-1:0] b
  );
    logic [WIDTH_D:0] s;
    s = {a[WIDTH_D-1], a} + {b[WIDTH_D-1], b};
    if (s[WIDTH_D] != s[WIDTH_D-1]) sat_add = s[WIDTH_D] ? SMIN : SMAX;
    else                            sat_add = s[WIDTH_D-1:0];
  endfunction

endpackage

// File: rtl/perceptron_seq_if.sv
// Host-side bundle of the perceptron sequencer.
// master: host (drives load/start/feature inputs, observes status/result).
// slave : perceptron_seq.
interface perceptron_seq_if
  import perceptron_pkg::*;
#(
  parameter int unsigned N_INPUTS = N_INPUTS_D,
  parameter int unsigned WIDTH    = WIDTH_D,
  parameter int unsigned ACC_W    = ACC_W_D
);
  localparam int unsigned AW = $clog2(N_INPUTS + 1);

  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic                      start;
  logic                      train;
  logic                      target;
  logic [N_INPUTS*WIDTH-1:0] x_in;
  logic                      busy;
  logic                      done;
  logic                      y_out;
  logic [ACC_W-1:0]          acc_out;
  logic                      updated;

  modport master (
    output wr_en, wr_addr, wr_data, start, train, target, x_in,
    input  busy, done, y_out, acc_out, updated
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, train, target, x_in,
    output busy, done, y_out, acc_out, updated
  );

endinterface

// File: rtl/perceptron_mac.sv
// Shared multiply-accumulate datapath.
// Ports: clk, reset (async, active-high); clr zeroes acc, load sets acc to
// load_val, en adds (w*x)>>>FRAC (floor, sign-extended) to acc.
// Priority clr > load > en; acc wraps in two's complement.
module perceptron_mac #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned FRAC  = 3,
  parameter int unsigned ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] scaled;
  logic signed [ACC_W-1:0]   p;

  assign prod   = w * x;
  assign scaled = prod >>> FRAC;
  assign p      = ACC_W'(scaled);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     acc <= '0;
    else if (clr)  acc <= '0;
    else if (load) acc <= load_val;
    else if (en)   acc <= acc + p;
  end

endmodule

// File: rtl/perceptron_seq.sv
// Sequencer for a time-multiplexed perceptron: y = (bias + sum w[i]*x[i] >= 0),
// one feature per cycle through a shared MAC, with an optional perceptron
// update pass (learning rate 1.0) when training and misclassified.
// Ports: clk; reset (async, active-high); bus (slave) carries weight/bias
// writes, start/train/target/x_in, and busy/done/y_out/acc_out/updated.
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int unsigned N_INPUTS = N_INPUTS_D,
  parameter int unsigned WIDTH    = WIDTH_D,
  parameter int unsigned FRAC     = FRAC_D,
  parameter int unsigned ACC_W    = ACC_W_D
) (
  input logic             clk,
  input logic             reset,
  perceptron_seq_if.slave bus
);

  localparam int unsigned AW = $clog2(N_INPUTS + 1);
  localparam int unsigned SW = $clog2(N_INPUTS);
  localparam logic [AW-1:0] LAST_X = AW'(N_INPUTS - 1);
  localparam logic [AW-1:0] BIAS_A = AW'(N_INPUTS);

  state_e state, state_n;

  logic [AW-1:0]           idx;
  logic [SW-1:0]           sel;
  logic signed [WIDTH-1:0] w     [N_INPUTS];
  logic signed [WIDTH-1:0] x_lat [N_INPUTS];
  logic signed [WIDTH-1:0] bias;
  logic                    train_q, target_q;
  logic signed [ACC_W-1:0] acc;
  logic                    mac_clr, mac_load, mac_en;
  logic                    y_now;
  logic signed [WIDTH-1:0] w_upd, b_upd;
  logic                    y_q, upd_q;
  logic [ACC_W-1:0]        acc_q;

  assign sel   = idx[SW-1:0];
  assign y_now = ~acc[ACC_W-1];

  // -x is formed as ~x + 1 through the saturating adder so that negating
  // the most-negative feature clamps to max before it is added to w.
  assign w_upd = sat_add(w[sel], target_q ? x_lat[sel]
                                          : sat_add(~x_lat[sel], WIDTH'(1)));
  assign b_upd = sat_add(bias, target_q ? ONE : -ONE);

  perceptron_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (mac_clr),
    .load     (mac_load),
    .en       (mac_en),
    .load_val (ACC_W'(bias)),
    .w        (w[sel]),
    .x        (x_lat[sel]),
    .acc      (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mac_clr  = 1'b0;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.wr_en && bus.start) begin
          state_n  = MAC;
          mac_load = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx == LAST_X) state_n = DECIDE;
      end
      DECIDE:  state_n = (train_q && (y_now != target_q)) ? UPDATE : DONE;
      UPDATE:  if (idx == BIAS_A) state_n = DONE;
      DONE: begin
        mac_clr = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      bias     <= '0;
      train_q  <= 1'b0;
      target_q <= 1'b0;
      y_q      <= 1'b0;
      upd_q    <= 1'b0;
      acc_q    <= '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        w[i]     <= '0;
        x_lat[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_en) begin
            if (bus.wr_addr == BIAS_A)      bias <= bus.wr_data;
            else if (bus.wr_addr < BIAS_A)  w[bus.wr_addr[SW-1:0]] <= bus.wr_data;
          end else if (bus.start) begin
            idx      <= '0;
            train_q  <= bus.train;
            target_q <= bus.target;
            for (int unsigned i = 0; i < N_INPUTS; i++)
              x_lat[i] <= bus.x_in[i*WIDTH +: WIDTH];
          end
        end
        MAC:    idx <= (idx == LAST_X) ? '0 : idx + AW'(1);
        DECIDE: idx <= '0;
        UPDATE: begin
          if (idx == BIAS_A) bias   <= b_upd;
          else               w[sel] <= w_upd;
          idx <= idx + AW'(1);
        end
        default: ;
      endcase

      // acc is frozen during UPDATE, so the result is captured on entry to DONE.
      if (state_n == DONE && state != DONE) begin
        y_q   <= y_now;
        acc_q <= acc;
        upd_q <= (state == UPDATE);
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.y_out   = y_q;
  assign bus.acc_out = acc_q;
  assign bus.updated = upd_q;

endmodule

// File: tb/tb_perceptron_seq.sv
module tb_perceptron_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  perceptron_seq_if #(.N_INPUTS(4), .WIDTH(6), .ACC_W(12)) bus ();

  perceptron_seq #(
    .N_INPUTS (4),
    .WIDTH    (6),
    .FRAC     (3),
    .ACC_W    (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int lat;
  int ndone;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = 6'(data);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load(input int w0, input int w1, input int w2, input int w3, input int b);
    wr(0, w0); wr(1, w1); wr(2, w2); wr(3, w3); wr(4, b);
  endtask

  task automatic set_x(input int a0, input int a1, input int a2, input int a3);
    bus.x_in = {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endtask

  // Start an operation and watch 20 cycles; lat = cycle index of first done
  // (start-sampling edge counts as cycle 1), ndone = number of done cycles.
  // inj > 0 pulses start plus a write of 5 to w[0] at that cycle.
  task automatic run_op(input logic tr, input logic tg, input int inj);
    lat = 0;
    ndone = 0;
    bus.train  = tr;
    bus.target = tg;
    bus.start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      if (inj > 0 && c == inj) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 6'd5;
      end else if (inj > 0 && c == inj + 1) begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = c;
      end
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b0) $display("FAIL rst_y: got %b expected 0", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd0) $display("FAIL rst_acc: got %0d expected 0", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b0) $display("FAIL rst_upd: got %b expected 0", bus.updated); else pass_cnt++;
  endtask

  task automatic test_inference();
    load(8, 8, 8, 8, 0);
    set_x(8, 8, 8, 8);
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (lat !== 6) $display("FAIL inf_latency: got %0d expected 6", lat); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL inf_done_count: got %0d expected 1", ndone); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd32) $display("FAIL inf_acc: got %0d expected 32", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b1) $display("FAIL inf_y: got %b expected 1", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b0) $display("FAIL inf_upd: got %b expected 0", bus.updated); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL inf_idle_busy: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_ignore_midop();
    load(8, 8, 8, 8, 0);
    set_x(8, 8, 8, 8);
    run_op(1'b0, 1'b0, 2);
    total_cnt++; if (lat !== 6) $display("FAIL mid_latency: got %0d expected 6", lat); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL mid_done_count: got %0d expected 1", ndone); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd32) $display("FAIL mid_acc: got %0d expected 32", $signed(bus.acc_out)); else pass_cnt++;
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'd32) $display("FAIL mid_w0_kept: got %0d expected 32", $signed(bus.acc_out)); else pass_cnt++;
  endtask

  task automatic test_train();
    load(0, 0, 0, 0, 0);
    set_x(8, 8, 8, 8);
    run_op(1'b1, 1'b0, 0);
    total_cnt++; if (lat !== 11) $display("FAIL trn_latency: got %0d expected 11", lat); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL trn_done_count: got %0d expected 1", ndone); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b1) $display("FAIL trn_y: got %b expected 1", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b1) $display("FAIL trn_upd: got %b expected 1", bus.updated); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd0) $display("FAIL trn_acc: got %0d expected 0", $signed(bus.acc_out)); else pass_cnt++;
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'hFD8) $display("FAIL trn_rerun_acc: got %0d expected -40", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b0) $display("FAIL trn_rerun_y: got %b expected 0", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b0) $display("FAIL trn_rerun_upd: got %b expected 0", bus.updated); else pass_cnt++;
  endtask

  task automatic test_saturation();
    load(28, 0, 0, 0, -32);
    set_x(8, 0, 0, 0);
    run_op(1'b1, 1'b1, 0);
    total_cnt++; if (bus.acc_out !== 12'hFFC) $display("FAIL sat_acc: got %0d expected -4", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b0) $display("FAIL sat_y: got %b expected 0", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b1) $display("FAIL sat_upd: got %b expected 1", bus.updated); else pass_cnt++;
    // w0 = 31 (clamped), bias = -24: 31 - 24 = 7
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'd7) $display("FAIL sat_w0: got %0d expected 7", $signed(bus.acc_out)); else pass_cnt++;
    set_x(0, 0, 0, 0);
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'hFE8) $display("FAIL sat_bias: got %0d expected -24", $signed(bus.acc_out)); else pass_cnt++;
    // Negating x=-32 clamps to 31 first: w0 = -1 + 31 = 30, bias = -8
    load(-1, 0, 0, 0, 0);
    set_x(-32, 0, 0, 0);
    run_op(1'b1, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'd4) $display("FAIL neg_acc: got %0d expected 4", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b1) $display("FAIL neg_upd: got %b expected 1", bus.updated); else pass_cnt++;
    set_x(8, 0, 0, 0);
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'd22) $display("FAIL neg_w0: got %0d expected 22", $signed(bus.acc_out)); else pass_cnt++;
  endtask

  task automatic test_neg_trunc();
    load(-1, 0, 0, 0, 0);
    set_x(1, 0, 0, 0);
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (bus.acc_out !== 12'hFFF) $display("FAIL trunc_acc: got %0d expected -1", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b0) $display("FAIL trunc_y: got %b expected 0", bus.y_out); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    load(8, 8, 8, 8, 8);
    set_x(8, 8, 8, 8);
    bus.train  = 1'b1;
    bus.target = 1'b0;
    bus.start  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
    end
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rmid_busy_before: got %b expected 1", bus.busy); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy_async: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd0) $display("FAIL rmid_acc_clr: got %0d expected 0", $signed(bus.acc_out)); else pass_cnt++;
    step();
    reset = 1'b0;
    step();
    run_op(1'b0, 1'b0, 0);
    total_cnt++; if (lat !== 6) $display("FAIL rmid_latency: got %0d expected 6", lat); else pass_cnt++;
    total_cnt++; if (bus.acc_out !== 12'd0) $display("FAIL rmid_weights_zero: got %0d expected 0", $signed(bus.acc_out)); else pass_cnt++;
    total_cnt++; if (bus.y_out !== 1'b1) $display("FAIL rmid_y: got %b expected 1", bus.y_out); else pass_cnt++;
    total_cnt++; if (bus.updated !== 1'b0) $display("FAIL rmid_upd: got %b expected 0", bus.updated); else pass_cnt++;
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.train   = 1'b0;
    bus.target  = 1'b0;
    bus.x_in    = '0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_inference();
    test_ignore_midop();
    test_train();
    test_saturation();
    test_neg_trunc();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
